// File: rtl/decode_select_pipe.sv
// ID-stage decode of one-hot read selects, destination select carried ID/EX -> EX/MEM -> MEM/WB
// (Dselect three edges after decode); load-use hazard raises a one-cycle stall and bubbles ID/EX.
module decode_select_pipe #(
  parameter int         NREGS  = 32,
  parameter logic [5:0] LW_OP  = 6'b100011,
  parameter logic [5:0] SW_OP  = 6'b101011,
  parameter logic [5:0] BEQ_OP = 6'b000100,
  parameter logic [5:0] BNE_OP = 6'b000101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ibus,
  input  logic             flush,
  output logic [NREGS-1:0] Aselect,
  output logic [NREGS-1:0] Bselect,
  output logic [NREGS-1:0] Dselect,
  output logic [NREGS-1:0] ex_dselect,
  output logic [NREGS-1:0] mem_dselect,
  output logic             stall
);

  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  logic [5:0]       opcode;
  logic [4:0]       rs, rt, rd;
  logic             unused_ibus;
  logic [NREGS-1:0] id_dsel;
  logic             rt_src;
  logic             hazard;
  logic             bubble;

  logic [NREGS-1:0] ex_dselect_q, ex_dselect_d;
  logic             ex_load_q, ex_load_d;
  logic [NREGS-1:0] mem_dselect_q;
  logic [NREGS-1:0] wb_dselect_q;

  assign opcode      = ibus[31:26];
  assign rs          = ibus[25:21];
  assign rt          = ibus[20:16];
  assign rd          = ibus[15:11];
  assign unused_ibus = ^ibus[10:0];

  assign Aselect = ONE << rs;
  assign Bselect = ONE << rt;

  always_comb begin
    id_dsel = ONE << rt;
    rt_src  = 1'b0;
    case (opcode)
      6'b000000: begin
        id_dsel = ONE << rd;
        rt_src  = 1'b1;
      end
      SW_OP, BEQ_OP, BNE_OP: begin
        id_dsel = '0;
        rt_src  = 1'b1;
      end
      default: ;
    endcase
  end

  // r0 loads never stall: bit 0 marks a write the register file discards.
  assign hazard = ex_load_q && (ex_dselect_q != '0) && !ex_dselect_q[0] &&
                  ((ex_dselect_q == Aselect) || (rt_src && (ex_dselect_q == Bselect)));
  assign stall  = hazard && !flush;
  assign bubble = flush || hazard;

  always_comb begin
    ex_dselect_d = bubble ? '0 : id_dsel;
    ex_load_d    = !bubble && (opcode == LW_OP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_dselect_q  <= '0;
      ex_load_q     <= 1'b0;
      mem_dselect_q <= '0;
      wb_dselect_q  <= '0;
    end else begin
      ex_dselect_q  <= ex_dselect_d;
      ex_load_q     <= ex_load_d;
      mem_dselect_q <= ex_dselect_q;
      wb_dselect_q  <= mem_dselect_q;
    end
  end

  assign ex_dselect  = ex_dselect_q;
  assign mem_dselect = mem_dselect_q;
  assign Dselect     = wb_dselect_q;

endmodule

// File: tb/tb_decode_select_pipe.sv
// Bench for decode_select_pipe: decode table plus hazard/flush/reset sequences, with a
// queue of expected destination selects checked as they reach EX, MEM and WB.
module tb_decode_select_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] ibus;
  logic        flush;
  logic [31:0] Aselect, Bselect, Dselect, ex_dselect, mem_dselect;
  logic        stall;

  decode_select_pipe dut (
    .clk(clk), .reset(reset), .ibus(ibus), .flush(flush),
    .Aselect(Aselect), .Bselect(Bselect), .Dselect(Dselect),
    .ex_dselect(ex_dselect), .mem_dselect(mem_dselect), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ib;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
  } vec_t;

  localparam logic [31:0] ADD_R3   = 32'h00221820; // add r3,r1,r2
  localparam logic [31:0] LW_R5    = 32'h8C250000; // lw r5,0(r1)
  localparam logic [31:0] ADD_R6   = 32'h00A23020; // add r6,r5,r2
  localparam logic [31:0] SW_R5    = 32'hAC250000; // sw r5,0(r1)
  localparam logic [31:0] ADDI_R7  = 32'h20A70001; // addi r7,r5,1
  localparam logic [31:0] LUI_R5   = 32'h3C050000; // lui r5,0
  localparam logic [31:0] LW_R0    = 32'h8C200000; // lw r0,0(r1)
  localparam logic [31:0] ADD_R6R0 = 32'h00003020; // add r6,r0,r0
  localparam logic [31:0] NOP      = 32'h00000000;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Drive one ID instruction; exp_enter is what must land in ID/EX at the next edge.
  task automatic cycle(input logic [31:0] ib, input logic fl, input logic [31:0] exp_enter,
                       input logic exp_stall, input logic [31:0] exp_a, input logic [31:0] exp_b);
    ibus  = ib;
    flush = fl;
    #1;
    chk("Aselect", Aselect, exp_a);
    chk("Bselect", Bselect, exp_b);
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    sb.push_back(exp_enter);
    @(posedge clk);
    #1;
    chk("Dselect", Dselect, sb.pop_front());
    chk("mem_dselect", mem_dselect, sb[0]);
    chk("ex_dselect", ex_dselect, sb[1]);
  endtask

  task automatic reset_sb();
    sb.delete();
    sb.push_back(32'h0);
    sb.push_back(32'h0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{ib: ADD_R3,       a: 32'h00000002, b: 32'h00000004, d: 32'h00000008};
    vecs[1] = '{ib: SW_R5,        a: 32'h00000002, b: 32'h00000020, d: 32'h00000000};
    vecs[2] = '{ib: 32'h10220008, a: 32'h00000002, b: 32'h00000004, d: 32'h00000000}; // beq r1,r2
    vecs[3] = '{ib: 32'h14640000, a: 32'h00000008, b: 32'h00000010, d: 32'h00000000}; // bne r3,r4
    vecs[4] = '{ib: ADDI_R7,      a: 32'h00000020, b: 32'h00000080, d: 32'h00000080};
    vecs[5] = '{ib: 32'h8D490004, a: 32'h00000400, b: 32'h00000200, d: 32'h00000200}; // lw r9,4(r10)
    vecs[6] = '{ib: 32'h03DDF825, a: 32'h40000000, b: 32'h20000000, d: 32'h80000000}; // or r31,r30,r29
    vecs[7] = '{ib: 32'h00000020, a: 32'h00000001, b: 32'h00000001, d: 32'h00000001}; // add r0,r0,r0
    vecs[8] = '{ib: 32'h3C0C1234, a: 32'h00000001, b: 32'h00001000, d: 32'h00001000}; // lui r12

    reset = 1'b1;
    flush = 1'b0;
    ibus  = ADD_R3;
    #2;
    chk("rst_ex_dselect", ex_dselect, 32'h0);
    chk("rst_mem_dselect", mem_dselect, 32'h0);
    chk("rst_Dselect", Dselect, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_Aselect", Aselect, 32'h00000002);
    chk("rst_Bselect", Bselect, 32'h00000004);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_sb();

    for (int i = 0; i < 9; i++)
      cycle(vecs[i].ib, 1'b0, vecs[i].d, 1'b0, vecs[i].a, vecs[i].b);
    for (int i = 0; i < 3; i++) cycle(NOP, 1'b0, 32'h1, 1'b0, 32'h1, 32'h1);

    // Load-use on rs: one stall cycle, bubble, then add retires with r6.
    cycle(LW_R5,  1'b0, 32'h20, 1'b0, 32'h2,  32'h20);
    cycle(ADD_R6, 1'b0, 32'h0,  1'b1, 32'h20, 32'h4);
    cycle(ADD_R6, 1'b0, 32'h40, 1'b0, 32'h20, 32'h4);
    for (int i = 0; i < 3; i++) cycle(NOP, 1'b0, 32'h1, 1'b0, 32'h1, 32'h1);

    // Store data register rt is a source.
    cycle(LW_R5, 1'b0, 32'h20, 1'b0, 32'h2, 32'h20);
    cycle(SW_R5, 1'b0, 32'h0,  1'b1, 32'h2, 32'h20);
    cycle(SW_R5, 1'b0, 32'h0,  1'b0, 32'h2, 32'h20);

    // I-type: rs matches, rt is a destination.
    cycle(LW_R5,   1'b0, 32'h20, 1'b0, 32'h2,  32'h20);
    cycle(ADDI_R7, 1'b0, 32'h0,  1'b1, 32'h20, 32'h80);
    cycle(ADDI_R7, 1'b0, 32'h80, 1'b0, 32'h20, 32'h80);

    // I-type writing the loaded register reads only r0: no stall.
    cycle(LW_R5,  1'b0, 32'h20, 1'b0, 32'h2, 32'h20);
    cycle(LUI_R5, 1'b0, 32'h20, 1'b0, 32'h1, 32'h20);

    // Load into r0 never stalls.
    cycle(LW_R0,    1'b0, 32'h1,  1'b0, 32'h2, 32'h1);
    cycle(ADD_R6R0, 1'b0, 32'h40, 1'b0, 32'h1, 32'h1);

    // Flush in the hazard cycle wins: no stall, bubble, squashed add never writes.
    cycle(LW_R5,  1'b0, 32'h20, 1'b0, 32'h2,  32'h20);
    cycle(ADD_R6, 1'b1, 32'h0,  1'b0, 32'h20, 32'h4);
    cycle(NOP,    1'b0, 32'h1,  1'b0, 32'h1,  32'h1);
    cycle(ADD_R3, 1'b1, 32'h0,  1'b0, 32'h2,  32'h4);
    for (int i = 0; i < 3; i++) cycle(NOP, 1'b0, 32'h1, 1'b0, 32'h1, 32'h1);

    // Asynchronous reset while a load-use stall is pending.
    cycle(ADD_R3, 1'b0, 32'h8,  1'b0, 32'h2, 32'h4);
    cycle(LW_R5,  1'b0, 32'h20, 1'b0, 32'h2, 32'h20);
    ibus  = ADD_R6;
    flush = 1'b0;
    #1;
    chk("pre_rst_stall", {31'b0, stall}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async_ex_dselect", ex_dselect, 32'h0);
    chk("async_mem_dselect", mem_dselect, 32'h0);
    chk("async_Dselect", Dselect, 32'h0);
    chk("async_stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_sb();
    cycle(ADD_R3, 1'b0, 32'h8, 1'b0, 32'h2, 32'h4);
    for (int i = 0; i < 3; i++) cycle(NOP, 1'b0, 32'h1, 1'b0, 32'h1, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
